// File: rtl/calc_disp_pkg.sv
// Shared encodings and defaults for the calculator display scheduler.
package calc_disp_pkg;

  typedef enum logic [2:0] {
    S_OP1       = 3'd0,
    S_PREVIEW   = 3'd1,
    S_OP2       = 3'd2,
    S_RES_FLASH = 3'd3,
    S_RES_HOLD  = 3'd4,
    S_ERR       = 3'd5
  } disp_state_e;

  typedef enum logic [1:0] {
    SRC_OP1 = 2'd0,
    SRC_OP2 = 2'd1,
    SRC_RES = 2'd2,
    SRC_SYM = 2'd3
  } disp_src_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  localparam logic [3:0]  ERR_DIGIT         = 4'hE;
  localparam int unsigned FLASH_TICKS_DEF   = 4;
  localparam int unsigned PREVIEW_TICKS_DEF = 6;

endpackage

// File: rtl/calc_zero_blank.sv
// Leading-zero blanking mask for a 7-digit BCD value; also flags an all-zero value.
module calc_zero_blank (
  input  logic [27:0] digits,
  input  logic [2:0]  dp_pos,
  input  logic [2:0]  keep_idx,
  output logic [6:0]  mask,
  output logic        is_zero
);

  // nz[k] is set when digit k or any higher digit is nonzero
  logic [6:0] nz;

  always_comb begin
    nz    = '0;
    mask  = '0;
    nz[6] = (digits[27:24] != 4'd0);
    for (int k = 5; k >= 0; k--) begin
      nz[k] = nz[k+1] | (digits[4*k +: 4] != 4'd0);
    end
    for (int k = 1; k < 7; k++) begin
      mask[k] = !nz[k] && (3'(k) > dp_pos) && (3'(k) != keep_idx);
    end
    is_zero = !nz[0];
  end

endmodule

// File: rtl/calc_display_sched.sv
// Display scheduler: picks operand/result/operator content per calculator state, with
// cursor blink, operator preview and result flash sequences.
module calc_display_sched
  import calc_disp_pkg::*;
#(
  parameter int unsigned FLASH_TICKS   = FLASH_TICKS_DEF,
  parameter int unsigned PREVIEW_TICKS = PREVIEW_TICKS_DEF
) (
  input  logic        clk_blink,
  input  logic        rst,
  input  logic [2:0]  calc_state,
  input  logic [2:0]  digit_pos,
  input  logic [27:0] digits1,
  input  logic [27:0] digits2,
  input  logic [27:0] result_digits,
  input  logic [2:0]  decimal_pos1,
  input  logic [2:0]  decimal_pos2,
  input  logic        is_negative1,
  input  logic        is_negative2,
  input  logic        is_result_negative,
  input  logic [1:0]  operation,
  input  logic        err,
  output logic [27:0] disp_digits,
  output logic        disp_neg,
  output logic [2:0]  disp_dp_pos,
  output logic [6:0]  disp_blank,
  output logic [1:0]  disp_src,
  output logic [1:0]  disp_op,
  output logic        busy
);

  localparam int unsigned CNT_MAX = (FLASH_TICKS > PREVIEW_TICKS) ? FLASH_TICKS : PREVIEW_TICKS;
  localparam int unsigned CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  logic [2:0]    calc_q;
  disp_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          same_group;

  logic [27:0] sel_digits, digits_d;
  logic [2:0]  sel_dp, sel_keep, dp_d;
  logic        sel_neg, sel_zero, neg_d, busy_d;
  logic [6:0]  zmask, blank_d, cursor;
  logic [1:0]  src_d, op_d;

  // Next state is decided from the registered calc_state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = ~phase_q;
    case (calc_q)
      3'd1:    same_group = (state_q == S_PREVIEW);
      3'd2:    same_group = (state_q == S_OP2);
      3'd3:    same_group = (state_q == S_RES_FLASH) || (state_q == S_RES_HOLD) ||
                            (state_q == S_ERR);
      default: same_group = (state_q == S_OP1);
    endcase
    if (!same_group) begin
      cnt_d = '0;
      case (calc_q)
        3'd1: begin
          state_d = S_PREVIEW;
          cnt_d   = CW'(PREVIEW_TICKS);
        end
        3'd2: state_d = S_OP2;
        3'd3: begin
          if (err) begin
            state_d = S_ERR;
          end else begin
            state_d = S_RES_FLASH;
            cnt_d   = CW'(FLASH_TICKS);
          end
        end
        default: state_d = S_OP1;
      endcase
    end else begin
      case (state_q)
        S_PREVIEW: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        S_RES_FLASH: begin
          if (cnt_q > CW'(1)) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = S_RES_HOLD;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Source select feeding the shared leading-zero mask.
  always_comb begin
    sel_digits = digits1;
    sel_dp     = decimal_pos1;
    sel_neg    = is_negative1;
    sel_keep   = 3'd0;
    case (state_d)
      S_OP1: sel_keep = digit_pos;
      S_OP2: begin
        sel_digits = digits2;
        sel_dp     = decimal_pos2;
        sel_neg    = is_negative2;
        sel_keep   = digit_pos;
      end
      S_RES_FLASH, S_RES_HOLD, S_ERR: begin
        sel_digits = result_digits;
        sel_dp     = 3'd0;
        sel_neg    = is_result_negative;
      end
      default: ;
    endcase
  end

  calc_zero_blank u_zero_blank (
    .digits   (sel_digits),
    .dp_pos   (sel_dp),
    .keep_idx (sel_keep),
    .mask     (zmask),
    .is_zero  (sel_zero)
  );

  assign cursor = 7'b1 << digit_pos;

  always_comb begin
    digits_d = sel_digits;
    neg_d    = sel_neg & ~sel_zero;
    dp_d     = sel_dp;
    blank_d  = zmask;
    src_d    = SRC_OP1;
    op_d     = 2'd0;
    busy_d   = (state_d == S_RES_FLASH) || ((state_d == S_PREVIEW) && (cnt_d != '0));
    case (state_d)
      S_OP1: if (phase_d) blank_d = zmask | cursor;
      S_OP2: begin
        src_d = SRC_OP2;
        if (phase_d) blank_d = zmask | cursor;
      end
      S_PREVIEW: begin
        if ((cnt_d == '0) || phase_d) begin
          src_d    = SRC_SYM;
          op_d     = operation;
          digits_d = '0;
          neg_d    = 1'b0;
          dp_d     = 3'd0;
          blank_d  = 7'b1111110;
        end
      end
      S_RES_FLASH: begin
        src_d = SRC_RES;
        if (phase_d) begin
          blank_d = 7'h7F;
          neg_d   = 1'b0;
        end
      end
      S_RES_HOLD: src_d = SRC_RES;
      S_ERR: begin
        src_d    = SRC_RES;
        digits_d = {7{ERR_DIGIT}};
        neg_d    = 1'b0;
        blank_d  = 7'b0000000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_blink or posedge rst) begin
    if (rst) begin
      calc_q      <= 3'd0;
      state_q     <= S_OP1;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      disp_digits <= '0;
      disp_neg    <= 1'b0;
      disp_dp_pos <= 3'd0;
      disp_blank  <= 7'b1111110;
      disp_src    <= SRC_OP1;
      disp_op     <= 2'd0;
      busy        <= 1'b0;
    end else begin
      calc_q      <= calc_state;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      disp_digits <= digits_d;
      disp_neg    <= neg_d;
      disp_dp_pos <= dp_d;
      disp_blank  <= blank_d;
      disp_src    <= src_d;
      disp_op     <= op_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_calc_display_sched.sv
// Self-checking bench for calc_display_sched: per-tick model comparison plus directed checks.
module tb_calc_display_sched;

  localparam int unsigned FT = 4;
  localparam int unsigned PT = 6;

  logic        clk_blink = 1'b0;
  logic        rst;
  logic [2:0]  calc_state, digit_pos, decimal_pos1, decimal_pos2;
  logic [27:0] digits1, digits2, result_digits;
  logic        is_negative1, is_negative2, is_result_negative, err;
  logic [1:0]  operation;
  logic [27:0] disp_digits;
  logic        disp_neg, busy;
  logic [2:0]  disp_dp_pos;
  logic [6:0]  disp_blank;
  logic [1:0]  disp_src, disp_op;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk_blink = ~clk_blink;

  calc_display_sched #(
    .FLASH_TICKS   (FT),
    .PREVIEW_TICKS (PT)
  ) dut (
    .clk_blink          (clk_blink),
    .rst                (rst),
    .calc_state         (calc_state),
    .digit_pos          (digit_pos),
    .digits1            (digits1),
    .digits2            (digits2),
    .result_digits      (result_digits),
    .decimal_pos1       (decimal_pos1),
    .decimal_pos2       (decimal_pos2),
    .is_negative1       (is_negative1),
    .is_negative2       (is_negative2),
    .is_result_negative (is_result_negative),
    .operation          (operation),
    .err                (err),
    .disp_digits        (disp_digits),
    .disp_neg           (disp_neg),
    .disp_dp_pos        (disp_dp_pos),
    .disp_blank         (disp_blank),
    .disp_src           (disp_src),
    .disp_op            (disp_op),
    .busy               (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Blank digit k when no nonzero digit sits at or above k, k is past the point, and k is
  // not the kept index.
  function automatic logic [6:0] lz(input logic [27:0] d, input int dp, input int keep);
    int h;
    logic [6:0] m;
    h = -1;
    m = '0;
    for (int k = 0; k < 7; k++) if (d[4*k +: 4] != 4'd0) h = k;
    for (int k = 1; k < 7; k++) m[k] = (k > h) && (k > dp) && (k != keep);
    return m;
  endfunction

  function automatic int grp(input logic [2:0] c);
    case (c)
      3'd1:    return 1;
      3'd2:    return 2;
      3'd3:    return 3;
      default: return 0;
    endcase
  endfunction

  // Model: display mode and ticks elapsed since that mode was entered.
  logic [2:0] m_cq;
  int         m_mode, m_n;
  bit         m_err, m_phase;

  always @(posedge clk_blink or posedge rst) begin
    if (rst) begin
      m_cq    <= 3'd0;
      m_mode  <= 0;
      m_n     <= 0;
      m_err   <= 1'b0;
      m_phase <= 1'b0;
    end else begin
      if (grp(m_cq) != m_mode) begin
        m_mode <= grp(m_cq);
        m_n    <= 0;
        m_err  <= err;
      end else begin
        m_n <= m_n + 1;
      end
      m_cq    <= calc_state;
      m_phase <= ~m_phase;
    end
  end

  logic [27:0] e_dig;
  logic        e_neg, e_busy;
  logic [2:0]  e_dp;
  logic [6:0]  e_blank;
  logic [1:0]  e_src, e_op;

  always @(posedge clk_blink) begin
    #1;
    if (chk_en && !rst) begin
      e_dig = '0; e_neg = 1'b0; e_dp = 3'd0; e_blank = 7'b1111110;
      e_src = 2'd0; e_op = 2'd0; e_busy = 1'b0;
      case (m_mode)
        0, 2: begin
          e_src   = (m_mode == 2) ? 2'd1 : 2'd0;
          e_dig   = (m_mode == 2) ? digits2 : digits1;
          e_dp    = (m_mode == 2) ? decimal_pos2 : decimal_pos1;
          e_neg   = ((m_mode == 2) ? is_negative2 : is_negative1) && (e_dig != 0);
          e_blank = lz(e_dig, int'(e_dp), int'(digit_pos));
          for (int k = 0; k < 7; k++) if (m_phase && k == int'(digit_pos)) e_blank[k] = 1'b1;
        end
        1: begin
          e_busy = (m_n < PT);
          if (e_busy && !m_phase) begin
            e_dig   = digits1;
            e_dp    = decimal_pos1;
            e_neg   = is_negative1 && (digits1 != 0);
            e_blank = lz(digits1, int'(decimal_pos1), 7);
          end else begin
            e_src = 2'd3;
            e_op  = operation;
          end
        end
        default: begin
          e_src = 2'd2;
          if (m_err) begin
            e_dig   = 28'hEEEEEEE;
            e_blank = 7'b0000000;
          end else begin
            e_busy = (m_n < FT);
            e_dig  = result_digits;
            if (e_busy && m_phase) begin
              e_blank = 7'h7F;
            end else begin
              e_blank = lz(result_digits, 0, 7);
              e_neg   = is_result_negative && (result_digits != 0);
            end
          end
        end
      endcase
      check("m_digits", disp_digits, e_dig);
      check("m_neg", disp_neg, e_neg);
      check("m_dp", disp_dp_pos, e_dp);
      check("m_blank", disp_blank, e_blank);
      check("m_src", disp_src, e_src);
      check("m_op", disp_op, e_op);
      check("m_busy", busy, e_busy);
    end
  end

  task automatic wait_busy(input string name);
    int k;
    k = 0;
    do begin
      @(posedge clk_blink); #2;
      k++;
    end while (!busy && k < 8);
    check(name, busy, 1);
  endtask

  task automatic count_busy(output int len, output int dark);
    len  = 0;
    dark = 0;
    while (busy && len < 20) begin
      len++;
      if (disp_blank == 7'h7F) dark++;
      @(posedge clk_blink); #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len, dark;
    rst = 1'b1; calc_state = 3'd0; digit_pos = 3'd6;
    digits1 = 28'h0000123; digits2 = '0; result_digits = '0;
    decimal_pos1 = 3'd0; decimal_pos2 = 3'd0;
    is_negative1 = 1'b0; is_negative2 = 1'b0; is_result_negative = 1'b0;
    operation = 2'd0; err = 1'b0;
    #3;
    check("rst_blank", disp_blank, 7'b1111110);
    check("rst_src", disp_src, 0);
    check("rst_busy", busy, 0);
    check("rst_digits", disp_digits, 0);
    @(negedge clk_blink); rst = 1'b0; chk_en = 1'b1;

    // cursor blink on digit 6 of 0000123
    @(posedge clk_blink); #2;
    check("cur_ph1", disp_blank, 7'b1111000);
    check("op1_digits", disp_digits, 28'h0000123);
    @(posedge clk_blink); #2;
    check("cur_ph0", disp_blank, 7'b0111000);

    // operator preview
    @(negedge clk_blink); operation = 2'd2; calc_state = 3'd1;
    wait_busy("prev_start");
    count_busy(len, dark);
    check("prev_len", len, PT);
    repeat (2) begin
      check("prev_src", disp_src, 3);
      check("prev_op", disp_op, 2);
      check("prev_busy", busy, 0);
      @(posedge clk_blink); #2;
    end

    // result flash then hold
    @(negedge clk_blink);
    result_digits = 28'h0000042; is_result_negative = 1'b1; err = 1'b0; calc_state = 3'd3;
    wait_busy("flash_start");
    count_busy(len, dark);
    check("flash_len", len, FT);
    check("flash_dark", dark, 2);
    check("hold_blank", disp_blank, 7'b1111100);
    check("hold_src", disp_src, 2);
    check("hold_neg", disp_neg, 1);
    @(posedge clk_blink); #2;
    check("hold_steady", disp_blank, 7'b1111100);

    // divide-by-zero result
    @(negedge clk_blink); calc_state = 3'd0;
    repeat (3) @(negedge clk_blink);
    err = 1'b1; calc_state = 3'd3;
    repeat (2) @(posedge clk_blink); #2;
    check("err_digits", disp_digits, 28'hEEEEEEE);
    check("err_blank", disp_blank, 0);
    check("err_busy", busy, 0);
    check("err_neg", disp_neg, 0);
    @(negedge clk_blink); err = 1'b0;
    @(posedge clk_blink); #2;
    check("err_steady", disp_digits, 28'hEEEEEEE);

    // abort a running flash
    @(negedge clk_blink); calc_state = 3'd0;
    repeat (3) @(negedge clk_blink);
    calc_state = 3'd3;
    wait_busy("abort_start");
    @(posedge clk_blink); #2;
    @(posedge clk_blink); #2;
    @(negedge clk_blink); calc_state = 3'd0;
    @(posedge clk_blink); #2;
    @(posedge clk_blink); #2;
    check("abort_busy", busy, 0);
    check("abort_src", disp_src, 0);

    // operand 2 with point and sign, then illegal state with a zero negative operand 1
    @(negedge clk_blink);
    digits2 = 28'h0000500; decimal_pos2 = 3'd3; is_negative2 = 1'b1; digit_pos = 3'd0;
    calc_state = 3'd2;
    repeat (2) @(posedge clk_blink); #2;
    check("op2_src", disp_src, 1);
    check("op2_dp", disp_dp_pos, 3);
    check("op2_neg", disp_neg, 1);
    check("op2_blank", disp_blank[6:1], 6'b111000);
    @(negedge clk_blink); digits1 = '0; is_negative1 = 1'b1; calc_state = 3'd5;
    repeat (2) @(posedge clk_blink); #2;
    check("illegal_src", disp_src, 0);
    check("zero_neg", disp_neg, 0);
    check("zero_blank", disp_blank[6:1], 6'b111111);

    // asynchronous reset in the middle of a preview
    @(negedge clk_blink); digits1 = 28'h0000789; is_negative1 = 1'b0; calc_state = 3'd1;
    wait_busy("prev2_start");
    @(posedge clk_blink); #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_src", disp_src, 0);
    check("arst_op", disp_op, 0);
    check("arst_blank", disp_blank, 7'b1111110);
    check("arst_digits", disp_digits, 0);
    check("arst_neg", disp_neg, 0);
    check("arst_dp", disp_dp_pos, 0);
    @(negedge clk_blink); @(negedge clk_blink); rst = 1'b0;
    repeat (12) @(negedge clk_blink);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
